// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath boundary for the multi-cycle MIPS32 core.
// The controller sits on the master side; the datapath (or a bench) on the slave side.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       i_opcode;
  logic [5:0]       i_funct;
  logic             i_zero;
  logic             i_mem_ready;
  logic             o_pc_write;
  logic [1:0]       o_pc_src;
  logic             o_ir_write;
  logic             o_iord;
  logic             o_mem_read;
  logic             o_mem_write;
  logic             o_alu_src_a;
  logic [1:0]       o_alu_src_b;
  logic [3:0]       o_alu_ctrl;
  logic             o_reg_write;
  logic [1:0]       o_reg_dst;
  logic [1:0]       o_mem_to_reg;
  logic [3:0]       o_state;
  logic             o_illegal;
  logic [CNT_W-1:0] o_instr_count;

  modport master (
    input  i_opcode, i_funct, i_zero, i_mem_ready,
    output o_pc_write, o_pc_src, o_ir_write, o_iord, o_mem_read, o_mem_write,
           o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_reg_write, o_reg_dst,
           o_mem_to_reg, o_state, o_illegal, o_instr_count
  );

  modport slave (
    output i_opcode, i_funct, i_zero, i_mem_ready,
    input  o_pc_write, o_pc_src, o_ir_write, o_iord, o_mem_read, o_mem_write,
           o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_reg_write, o_reg_dst,
           o_mem_to_reg, o_state, o_illegal, o_instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS32 core: sequences ALU, register
// file, PC, IR and the unified memory port; counts retired instructions and
// traps on encodings it does not implement.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory completes
// DECODE | branch target into ALUOut, dispatch on opcode
// MADDR  | rs + imm effective address for LW/SW
// MRD    | load read, wait for memory
// MWB    | write MDR into rt
// MWR    | store write, wait for memory
// REXE   | R-type ALU operation
// RWB    | write ALUOut into rd
// BR     | BEQ/BNE compare, conditional PC load
// JMP    | J
// IEXE   | immediate ALU operation
// IWB    | write ALUOut into rt
// JAL    | link into $31 and jump
// JR     | PC <= rs
// TRAP   | illegal encoding, parked until reset
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
    S_MWR = 4'd5, S_REXE = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_IEXE = 4'd10, S_IWB = 4'd11, S_JAL = 4'd12, S_JR = 4'd13, S_TRAP = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR = 4'b0011, ALU_SLT = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_NOR = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001, ALU_SLTU = 4'b1010, ALU_BEQ = 4'b1100,
                         ALU_BNE = 4'b1110, ALU_LUI = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, FN_JR = 6'b001000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;

  logic       r_legal, i_legal;
  logic [3:0] r_alu, i_alu;

  logic       pc_write, ir_write, iord, mem_read, mem_write, alu_src_a, reg_write;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0] alu_ctrl;

  // R-type funct to ALU code; ADDU/SUBU decode as illegal
  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (bus.i_funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b101011: r_alu = ALU_SLTU;
      6'b000000, 6'b000100: r_alu = ALU_SLL;
      6'b000010, 6'b000110: r_alu = ALU_SRL;
      6'b000011, 6'b000111: r_alu = ALU_SRA;
      default:   r_legal = 1'b0;
    endcase
  end

  // Immediate-class opcode to ALU code
  always_comb begin
    i_legal = 1'b1;
    i_alu   = ALU_ADD;
    case (bus.i_opcode)
      6'b001000: i_alu = ALU_ADD;
      6'b001010: i_alu = ALU_SLT;
      6'b001011: i_alu = ALU_SLTU;
      6'b001100: i_alu = ALU_AND;
      6'b001101: i_alu = ALU_OR;
      6'b001110: i_alu = ALU_XOR;
      6'b001111: i_alu = ALU_LUI;
      default:   i_legal = 1'b0;
    endcase
  end

  // Next state and Moore strobes (plus the ready/zero gated PC loads)
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.i_mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.i_opcode)
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_RTYPE:     state_d = (bus.i_funct == FN_JR) ? S_JR : (r_legal ? S_REXE : S_TRAP);
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:         state_d = S_JMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = i_legal ? S_IEXE : S_TRAP;
        endcase
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.i_opcode == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.i_mem_ready) state_d = S_MWB;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_MWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.i_mem_ready) state_d = S_FETCH;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        state_d   = S_FETCH;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        alu_ctrl  = (bus.i_opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
        pc_write  = (bus.i_opcode == OP_BNE) ? ~bus.i_zero : bus.i_zero;
        state_d   = S_FETCH;
      end
      S_JMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = i_alu;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State register, retire counter and sticky illegal flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != S_FETCH && state_d == S_FETCH) count_q <= count_q + 1'b1;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Strobes are forced low for as long as reset is held
  assign bus.o_pc_write    = i_rst_n & pc_write;
  assign bus.o_pc_src      = i_rst_n ? pc_src : 2'b00;
  assign bus.o_ir_write    = i_rst_n & ir_write;
  assign bus.o_iord        = i_rst_n & iord;
  assign bus.o_mem_read    = i_rst_n & mem_read;
  assign bus.o_mem_write   = i_rst_n & mem_write;
  assign bus.o_alu_src_a   = i_rst_n & alu_src_a;
  assign bus.o_alu_src_b   = i_rst_n ? alu_src_b : 2'b00;
  assign bus.o_alu_ctrl    = i_rst_n ? alu_ctrl : 4'b0000;
  assign bus.o_reg_write   = i_rst_n & reg_write;
  assign bus.o_reg_dst     = i_rst_n ? reg_dst : 2'b00;
  assign bus.o_mem_to_reg  = i_rst_n ? mem_to_reg : 2'b00;
  assign bus.o_state       = state_q;
  assign bus.o_illegal     = illegal_q;
  assign bus.o_instr_count = count_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl (4-bit retire counter build). An
// instruction-level model expands each instruction into its expected
// per-cycle control outputs; the DUT is compared every cycle.
module tb_mips_multicycle_ctrl;
  localparam int FETCH = 0, DECODE = 1, MADDR = 2, MRD = 3, MWB = 4, MWR = 5, REXE = 6,
                 RWB = 7, BR = 8, JMP = 9, IEXE = 10, IWB = 11, JAL = 12, JR = 13, TRAP = 14;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_BEQ = 4, C_BNE = 5, C_J = 6,
                 C_JAL = 7, C_I = 8, C_ILL = 9;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic [3:0] count;
  } obs_t;

  typedef struct {
    obs_t       exp;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       ready;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(4)) bus ();
  mips_multicycle_ctrl #(.CNT_W(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  step_t      q[$];
  logic [3:0] mcount;
  logic       mill;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [5:0] ops [14] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13,
                           6'd14, 6'd15, 6'd35, 6'd43};
  logic [5:0] fns [15] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd0,
                           6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8};

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'd0: case (fn)
        6'd8: return C_JR;
        6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43,
        6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7: return C_R;
        default: return C_ILL;
      endcase
      6'd2:  return C_J;
      6'd3:  return C_JAL;
      6'd4:  return C_BEQ;
      6'd5:  return C_BNE;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: return C_I;
      default: return C_ILL;
    endcase
  endfunction

  // ALU mnemonic table: ADD 0 SUB 1 AND 2 OR 3 SLT 4 XOR 5 NOR 6 SLL 7 SRL 8 SRA 9 SLTU 10 LUI 15
  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'd34: return 4'd1;
      6'd36: return 4'd2;
      6'd37: return 4'd3;
      6'd42: return 4'd4;
      6'd38: return 4'd5;
      6'd39: return 4'd6;
      6'd0, 6'd4: return 4'd7;
      6'd2, 6'd6: return 4'd8;
      6'd3, 6'd7: return 4'd9;
      6'd43: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(logic [5:0] op);
    case (op)
      6'd10: return 4'd4;
      6'd11: return 4'd10;
      6'd12: return 4'd2;
      6'd13: return 4'd3;
      6'd14: return 4'd5;
      6'd15: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic obs_t base(int st);
    obs_t e = '0;
    e.state   = 4'(st);
    e.illegal = mill;
    e.count   = mcount;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = bus.o_state;          o.pc_write = bus.o_pc_write;
    o.pc_src = bus.o_pc_src;        o.ir_write = bus.o_ir_write;
    o.iord = bus.o_iord;            o.mem_read = bus.o_mem_read;
    o.mem_write = bus.o_mem_write;  o.src_a = bus.o_alu_src_a;
    o.src_b = bus.o_alu_src_b;      o.alu = bus.o_alu_ctrl;
    o.reg_write = bus.o_reg_write;  o.reg_dst = bus.o_reg_dst;
    o.mem_to_reg = bus.o_mem_to_reg; o.illegal = bus.o_illegal;
    o.count = bus.o_instr_count;
    return o;
  endfunction

  task automatic push(obs_t e, logic [5:0] op, logic [5:0] fn, logic zero, logic ready);
    step_t s;
    s.exp = e; s.op = op; s.fn = fn; s.zero = zero; s.ready = ready;
    q.push_back(s);
  endtask

  // Memory waits: 'w' cycles with ready low, then one with ready high
  task automatic push_wait(obs_t e, int w, logic [5:0] op, logic [5:0] fn, logic zero);
    for (int i = 0; i < w; i++) push(e, op, fn, zero, 1'b0);
    push(e, op, fn, zero, 1'b1);
  endtask

  task automatic add_instr(logic [5:0] op, logic [5:0] fn, logic zero, int fwait, int mwait);
    obs_t e;
    int   c = classify(op, fn);
    e = base(FETCH); e.mem_read = 1'b1; e.src_b = 2'b01;
    for (int i = 0; i < fwait; i++) push(e, op, fn, zero, 1'b0);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, op, fn, zero, 1'b1);
    e = base(DECODE); e.src_b = 2'b11;
    push(e, op, fn, zero, 1'($urandom));
    if (c == C_LW || c == C_SW) begin
      e = base(MADDR); e.src_a = 1'b1; e.src_b = 2'b10;
      push(e, op, fn, zero, 1'($urandom));
    end
    case (c)
      C_LW: begin
        e = base(MRD); e.iord = 1'b1; e.mem_read = 1'b1;
        push_wait(e, mwait, op, fn, zero);
        e = base(MWB); e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_SW: begin
        e = base(MWR); e.iord = 1'b1; e.mem_write = 1'b1;
        push_wait(e, mwait, op, fn, zero);
      end
      C_R: begin
        e = base(REXE); e.src_a = 1'b1; e.alu = r_alu(fn);
        push(e, op, fn, zero, 1'($urandom));
        e = base(RWB); e.reg_write = 1'b1; e.reg_dst = 2'b01;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_I: begin
        e = base(IEXE); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = i_alu(op);
        push(e, op, fn, zero, 1'($urandom));
        e = base(IWB); e.reg_write = 1'b1;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_BEQ, C_BNE: begin
        e = base(BR); e.src_a = 1'b1; e.pc_src = 2'b01;
        e.alu = (c == C_BEQ) ? 4'b1100 : 4'b1110;
        e.pc_write = (c == C_BEQ) ? zero : ~zero;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_J: begin
        e = base(JMP); e.pc_write = 1'b1; e.pc_src = 2'b10;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_JR: begin
        e = base(JR); e.pc_write = 1'b1; e.pc_src = 2'b11;
        push(e, op, fn, zero, 1'($urandom));
      end
      C_JAL: begin
        e = base(JAL); e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        e.pc_write = 1'b1; e.pc_src = 2'b10;
        push(e, op, fn, zero, 1'($urandom));
      end
      default: begin
        mill = 1'b1;
        for (int i = 0; i < 10; i++) push(base(TRAP), op, fn, zero, 1'($urandom));
      end
    endcase
    if (c != C_ILL) mcount = mcount + 4'd1;
  endtask

  task automatic run_q();
    step_t s;
    obs_t  o;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_opcode = s.op; bus.i_funct = s.fn; bus.i_zero = s.zero; bus.i_mem_ready = s.ready;
      #1;
      o = sample();
      cyc++;
      checks++;
      assert (o === s.exp) else begin
        errors++;
        $error("FAIL cycle%0d state/strobes got %h expected %h", cyc, o, s.exp);
      end
    end
  endtask

  // One clock with reset low; strobes must be low during it
  task automatic do_reset();
    obs_t o;
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_mem_ready = 1'($urandom); bus.i_zero = 1'($urandom);
    #1;
    o = sample();
    o.state = '0; o.illegal = 1'b0; o.count = '0;
    checks++;
    assert (o === obs_t'(0)) else begin
      errors++;
      $error("FAIL reset_strobes got %h expected 0", o);
    end
    mcount = '0;
    mill   = 1'b0;
  endtask

  initial begin
    bus.i_opcode = '0; bus.i_funct = '0; bus.i_zero = 1'b0; bus.i_mem_ready = 1'b0;
    mcount = '0; mill = 1'b0;

    do_reset();
    add_instr(6'd0, 6'd32, 1'b0, 0, 0);
    add_instr(6'd35, 6'd0, 1'b0, 0, 3);
    add_instr(6'd4, 6'd0, 1'b1, 0, 0);
    add_instr(6'd5, 6'd0, 1'b1, 0, 0);
    add_instr(6'd3, 6'd0, 1'b0, 0, 0);
    add_instr(6'd0, 6'd8, 1'b0, 1, 0);
    run_q();

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(0, 13)];
      fn = (op == 6'd0) ? fns[$urandom_range(0, 14)] : 6'($urandom);
      add_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run_q();

    do_reset();
    for (int n = 0; n < 16; n++) add_instr(6'd0, 6'd32, 1'b0, 0, 0);
    add_instr(6'd2, 6'd0, 1'b0, 0, 0);
    run_q();

    add_instr(6'd63, 6'd0, 1'b0, 0, 0);
    run_q();
    do_reset();
    add_instr(6'd0, 6'd34, 1'b0, 0, 0);
    add_instr(6'd0, 6'd1, 1'b0, 0, 0);
    run_q();

    do_reset();
    add_instr(6'd43, 6'd0, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) void'(q.pop_back());
    run_q();
    do_reset();
    add_instr(6'd15, 6'd0, 1'b0, 0, 0);
    add_instr(6'd2, 6'd0, 1'b0, 0, 0);
    run_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
